// File: rtl/ray_dispatcher_pkg.sv
// Shared ray-tracing types: fixed-point vectors and the FIFO entry carried
// from the ray caster to the tracer core.
package ray_dispatcher_pkg;

    typedef struct packed {
        logic [23:0] x;
        logic [23:0] y;
        logic [23:0] z;
    } fp24_vec3;

    typedef struct packed {
        fp24_vec3    origin;
        fp24_vec3    dir;
        logic [10:0] pixel_h;
        logic [9:0]  pixel_v;
    } ray_entry;

endpackage

// File: rtl/ray_fifo.sv
// Generic show-ahead synchronous FIFO. The head entry is visible on rdata
// whenever the FIFO is not empty. A push into a full FIFO is accepted only
// when a pop frees the slot in the same cycle. count_next exposes the
// occupancy the FIFO will hold after this clock edge, so the caller can
// meter upstream requests without adding a cycle of latency.
module ray_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wdata,
    output T                         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T             mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_acc;
    logic          pop_acc;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || pop_acc);
    assign rdata    = mem[rd_ptr];

    // Occupancy after this edge: push and pop together leave it unchanged.
    always_comb begin
        count_next = count;
        case ({push_acc, pop_acc})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Entry storage carries data only, so it is never reset.
    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ray_dispatcher.sv
// Buffers rays from the ray caster and presents them to the tracer core.
// new_ray requests are credit-metered so every released ray has a slot;
// frame_done pulses after the last pixel of a frame is handed out, and
// overflow latches if the caster ever pushes into a full buffer anyway.
module ray_dispatcher
    import ray_dispatcher_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    output logic                   new_ray,
    input  logic                   ray_valid,
    input  fp24_vec3               ray_origin,
    input  fp24_vec3               ray_dir,
    input  logic [10:0]            pixel_h,
    input  logic [9:0]             pixel_v,
    output logic                   out_valid,
    input  logic                   out_ready,
    output ray_entry               out_ray,
    output logic [$clog2(DEPTH):0] count,
    output logic                   frame_done,
    output logic                   overflow
);

    localparam int          CW         = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);
    localparam logic [10:0] LAST_H     = 11'(WIDTH - 1);
    localparam logic [9:0]  LAST_V     = 10'(HEIGHT - 1);

    logic          inflight;
    logic          inflight_next;
    logic          new_ray_next;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] count_next;
    logic [CW:0]   committed;
    ray_entry      wdata;

    function automatic logic is_last_pixel(input ray_entry e);
        return (e.pixel_h == LAST_H) && (e.pixel_v == LAST_V);
    endfunction

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign wdata     = '{origin: ray_origin, dir: ray_dir,
                         pixel_h: pixel_h, pixel_v: pixel_v};

    ray_fifo #(
        .DEPTH (DEPTH),
        .T     (ray_entry)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (ray_valid),
        .pop        (pop),
        .wdata      (wdata),
        .rdata      (out_ray),
        .count      (count),
        .count_next (count_next),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Credit check on next-cycle state: slots that will be occupied plus the
    // ray still owed by the caster must leave room for one more request.
    always_comb begin
        inflight_next = new_ray | (inflight & ~ray_valid);
        committed     = {1'b0, count_next} + {{CW{1'b0}}, inflight_next};
        new_ray_next  = run && (committed < CREDIT_MAX);
    end

    // Request strobe, in-flight tracking, frame-end pulse and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            new_ray    <= 1'b0;
            inflight   <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            new_ray    <= new_ray_next;
            inflight   <= inflight_next;
            frame_done <= pop && is_last_pixel(out_ray);
            overflow   <= overflow | (ray_valid && fifo_full && !pop);
        end
    end

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed bench for ray_dispatcher with a 1-cycle caster model that emits
// sequential pixels in response to new_ray.
module tb_ray_dispatcher;
    import ray_dispatcher_pkg::*;

    localparam int DEPTH  = 4;
    localparam int WIDTH  = 1280;
    localparam int HEIGHT = 720;
    localparam int NPIX   = WIDTH * HEIGHT;

    typedef struct {
        logic       run;
        logic       rdy;
        logic       nr;
        logic       ov;
        logic [2:0] cnt;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       run;
    logic       new_ray;
    logic       ray_valid;
    fp24_vec3   ray_origin;
    fp24_vec3   ray_dir;
    logic [10:0] pixel_h;
    logic [9:0]  pixel_v;
    logic       out_valid;
    logic       out_ready;
    ray_entry   out_ray;
    logic [2:0] count;
    logic       frame_done;
    logic       overflow;

    int   checks   = 0;
    int   errors   = 0;
    logic force_rv = 1'b0;
    int   pix_base = 0;
    int   emit_cnt = 0;
    vec_t tbl [34];

    ray_dispatcher #(.DEPTH(DEPTH), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .new_ray    (new_ray),
        .ray_valid  (ray_valid),
        .ray_origin (ray_origin),
        .ray_dir    (ray_dir),
        .pixel_h    (pixel_h),
        .pixel_v    (pixel_v),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ray    (out_ray),
        .count      (count),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caster model: new_ray seen in cycle t -> ray_valid in cycle t+1.
    initial begin : caster
        logic pend;
        logic frc;
        int   idx;
        ray_valid  = 1'b0;
        ray_origin = '0;
        ray_dir    = '0;
        pixel_h    = '0;
        pixel_v    = '0;
        forever begin
            @(negedge clk);
            pend = new_ray;
            frc  = force_rv;
            @(posedge clk);
            #1;
            if (frc) begin
                ray_valid  = 1'b1;
                ray_origin = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
                ray_dir    = '0;
                pixel_h    = 11'd77;
                pixel_v    = 10'd33;
            end else if (pend) begin
                idx          = (pix_base + emit_cnt) % NPIX;
                emit_cnt     = emit_cnt + 1;
                pixel_h      = 11'(idx % WIDTH);
                pixel_v      = 10'(idx / WIDTH);
                ray_origin.x = 24'(idx % WIDTH);
                ray_origin.y = 24'(idx / WIDTH);
                ray_origin.z = 24'hA5A5A5;
                ray_dir      = ~ray_origin;
                ray_valid    = 1'b1;
            end else begin
                ray_valid = 1'b0;
            end
        end
    end

    // Holds reset, aims the caster at first_pix, releases at posedge+1 (cycle 0).
    task automatic do_reset(input int first_pix);
        rst       = 1'b0;
        run       = 1'b0;
        out_ready = 1'b0;
        force_rv  = 1'b0;
        repeat (2) tick();
        pix_base = ((first_pix - (emit_cnt % NPIX)) % NPIX + NPIX) % NPIX;
        tick();
        rst = 1'b1;
    endtask

    initial begin : main
        int nr_pulses;
        int eidx;
        rst       = 1'b0;
        run       = 1'b0;
        out_ready = 1'b0;

        // Backpressure from reset: run=1, out_ready=0, one pop at row 27.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd2};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd3};
        for (int i = 6; i < 27; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd4};
        tbl[27] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd4};
        tbl[28] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd3};
        tbl[29] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd3};
        for (int i = 30; i < 34; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd4};

        do_reset(0);
        for (int i = 0; i < 34; i++) begin
            run       = tbl[i].run;
            out_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("bp[%0d].new_ray", i),    32'(new_ray),    32'(tbl[i].nr));
            chk($sformatf("bp[%0d].out_valid", i),  32'(out_valid),  32'(tbl[i].ov));
            chk($sformatf("bp[%0d].count", i),      32'(count),      32'(tbl[i].cnt));
            chk($sformatf("bp[%0d].overflow", i),   32'(overflow),   32'd0);
            chk($sformatf("bp[%0d].frame_done", i), 32'(frame_done), 32'd0);
            tick();
        end
        out_ready = 1'b0;

        // Forced push into the full FIFO: entry dropped, overflow sticks.
        force_rv = 1'b1;
        tick();
        force_rv = 1'b0;
        @(negedge clk);
        chk("ovf.ray_valid", 32'(ray_valid), 32'd1);
        chk("ovf.before",    32'(overflow),  32'd0);
        tick();
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk($sformatf("ovf[%0d].overflow", j), 32'(overflow), 32'd1);
            chk($sformatf("ovf[%0d].count", j),    32'(count),    32'd4);
            chk($sformatf("ovf[%0d].head_h", j),   32'(out_ray.pixel_h),  32'd1);
            chk($sformatf("ovf[%0d].head_v", j),   32'(out_ray.pixel_v),  32'd0);
            chk($sformatf("ovf[%0d].head_ox", j),  32'(out_ray.origin.x), 32'd1);
            tick();
        end

        // Reset mid-run with count=3, then a ray in the first cycle after release.
        do_reset(0);
        run = 1'b1;
        repeat (5) tick();
        chk("rmid.count_pre", 32'(count),     32'd3);
        chk("rmid.ov_pre",    32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("rmid.new_ray",   32'(new_ray),   32'd0);
        chk("rmid.out_valid", 32'(out_valid), 32'd0);
        chk("rmid.count",     32'(count),     32'd0);
        chk("rmid.overflow",  32'(overflow),  32'd0);
        force_rv = 1'b1;
        pix_base = ((0 - (emit_cnt % NPIX)) % NPIX + NPIX) % NPIX;
        tick();
        force_rv = 1'b0;
        rst      = 1'b1;
        run      = 1'b1;
        @(negedge clk);
        chk("rrel.c0_new_ray", 32'(new_ray), 32'd0);
        tick();
        @(negedge clk);
        chk("rrel.c1_new_ray",   32'(new_ray),   32'd1);
        chk("rrel.c1_count",     32'(count),     32'd1);
        chk("rrel.c1_out_valid", 32'(out_valid), 32'd1);
        chk("rrel.c1_head_h",    32'(out_ray.pixel_h), 32'd77);
        chk("rrel.c1_head_v",    32'(out_ray.pixel_v), 32'd33);
        tick();

        // Streaming with out_ready=1: continuous from cycle 3, pixels in order.
        do_reset(0);
        run       = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c < 3) begin
                chk($sformatf("strm[%0d].out_valid", c), 32'(out_valid), 32'd0);
            end else begin
                chk($sformatf("strm[%0d].out_valid", c), 32'(out_valid), 32'd1);
                chk($sformatf("strm[%0d].pixel_h", c),   32'(out_ray.pixel_h), c - 3);
                chk($sformatf("strm[%0d].pixel_v", c),   32'(out_ray.pixel_v), 32'd0);
            end
            tick();
        end

        // Frame wrap: (1279,719) popped at end of cycle 4 -> frame_done in cycle 5.
        do_reset(NPIX - 2);
        run       = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("wrap[%0d].frame_done", c), 32'(frame_done), (c == 5) ? 32'd1 : 32'd0);
            if (c >= 3) begin
                eidx = (NPIX - 2 + c - 3) % NPIX;
                chk($sformatf("wrap[%0d].pixel_h", c), 32'(out_ray.pixel_h), eidx % WIDTH);
                chk($sformatf("wrap[%0d].pixel_v", c), 32'(out_ray.pixel_v), eidx / WIDTH);
            end
            tick();
        end

        // run dropped in the same cycle as the first new_ray pulse.
        do_reset(0);
        run = 1'b1;
        tick();
        run = 1'b0;
        @(negedge clk);
        chk("drop.c1_new_ray", 32'(new_ray), 32'd1);
        nr_pulses = 0;
        for (int c = 2; c <= 10; c++) begin
            tick();
            @(negedge clk);
            nr_pulses += int'(new_ray);
            if (c == 3) chk("drop.c3_count", 32'(count), 32'd1);
        end
        chk("drop.new_ray_pulses", nr_pulses, 32'd0);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("drop.pop_valid",   32'(out_valid),       32'd1);
        chk("drop.pop_pixel_h", 32'(out_ray.pixel_h), 32'd0);
        tick();
        @(negedge clk);
        chk("drop.final_count", 32'(count),     32'd0);
        chk("drop.final_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
